uart_rx_framer: RTL and testbench

- Receive front end of the serial device: 8N1, LSB-first UART receiver on the board's 50 MHz clock at 115200 baud.
- Pipeline position: takes the asynchronous rx pin; delivers one byte per frame over a valid/ack handshake to the downstream consumer (byte buffer / LCD character writer).
- Reports framing errors and dropped bytes (overrun).

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_framer_rx_sync.sv | 19 +
 rtl/uart_rx_framer.sv | 117 +++++++++++
 tb/tb_uart_rx_framer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, default bit timing and sampling helper for the UART receive path
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    // 50 MHz / 115200 baud
    localparam int CLKS_PER_BIT_DEF = 434;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_framer_rx_sync.sv
// rx_sync: two-flop synchronizer for the asynchronous rx pin
//   clk   in  system clock
//   reset in  async active-low reset; both flops preset to the idle-high line level
//   rx    in  raw serial line
//   rx_s  out synchronized line, two cycles behind rx
module rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);

    logic s1;

    always_ff @(posedge clk or negedge reset)
        if (!reset) {rx_s, s1} <= 2'b11;
        else        {rx_s, s1} <= {s1, rx};

endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: 8N1 LSB-first UART receiver with valid/ack byte handshake
//   clk       in  system clock
//   reset     in  async active-low reset
//   init      in  sync soft clear: abandon frame, go idle, clear flags
//   rx        in  serial line, idles high
//   out_data  out received byte, stable while rx_valid
//   rx_valid  out byte available, held until rx_ack
//   rx_ack    in  consumer took out_data
//   frame_err out one-cycle pulse when the stop bit samples low
//   overrun   out sticky, a byte completed while rx_valid was still set
//   busy      out receiver is inside a frame
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;

    rx_state_t state, next_state;
    logic rx_s, prev_rx_s, prev2_rx_s;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic sample, tick, last_bit, stop_ok, stop_bad, clr_cnt;

    rx_sync u_sync (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .rx_s (rx_s)
    );

    // Majority over the last three rx_s values; at a tick these straddle the bit centre.
    assign sample = maj3(prev2_rx_s, prev_rx_s, rx_s);

    // The start decision lands one count past the half-bit centre. Data/stop decisions
    // land CLKS_PER_BIT cycles after the previous decision, keeping every later window
    // centred on its bit.
    assign tick = (state == START) ? (cnt == CW'(HALF_BIT + 1)) : (cnt == CW'(CLKS_PER_BIT - 1));
    assign last_bit = bit_idx == 3'd7;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = (prev_rx_s && !rx_s) ? START : IDLE;
            START: next_state = tick ? (sample ? IDLE : DATA) : START;
            DATA:  next_state = (tick && last_bit) ? STOP : DATA;
            STOP:  next_state = tick ? IDLE : STOP;
            default: next_state = IDLE;
        endcase
        if (init) next_state = IDLE;
    end

    always_comb begin
        busy     = state != IDLE;
        stop_ok  = (state == STOP) && tick && sample;
        stop_bad = (state == STOP) && tick && !sample;
        clr_cnt  = (state == IDLE) || tick;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) {prev2_rx_s, prev_rx_s} <= 2'b11;
        else        {prev2_rx_s, prev_rx_s} <= {prev_rx_s, rx_s};

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            out_data  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (init) begin
            cnt       <= '0;
            bit_idx   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            cnt       <= clr_cnt ? '0 : cnt + 1'b1;
            frame_err <= stop_bad;
            if (state == START)
                bit_idx <= '0;
            if (state == DATA && tick) begin
                shreg   <= {sample, shreg[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            // An ack in the same cycle as a completion frees the slot for the new byte.
            if (stop_ok && (!rx_valid || rx_ack)) begin
                out_data <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
            if (stop_ok && rx_valid && !rx_ack)
                overrun <= 1'b1;
        end

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: scoreboard bench for uart_rx_framer
module tb_uart_rx_framer;

    localparam int BIT = 8680;

    logic clk = 1'b0, reset = 1'b0, init = 1'b0, rx = 1'b1, rx_ack = 1'b0;
    logic [7:0] out_data;
    logic rx_valid, frame_err, overrun, busy;

    logic [7:0] exp_q[$];
    int checks = 0, errors = 0, fe_cycles = 0, n;
    logic pv = 1'b0;

    always #10 clk = ~clk;

    uart_rx_framer dut (
        .clk      (clk),
        .reset    (reset),
        .init     (init),
        .rx       (rx),
        .out_data (out_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        #(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(BIT);
        end
        rx = stop;
        #(BIT);
        rx = 1'b1;
    endtask

    task automatic ack_byte(input string tag);
        int w = 0;
        while (!rx_valid && w < 6000) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_valid"}, 32'(rx_valid), 1);
        rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
        check({tag, "_drop"}, 32'(rx_valid), 0);
    endtask

    task automatic pulse_init();
        @(posedge clk);
        #1 init = 1'b1;
        @(posedge clk);
        #1 init = 1'b0;
    endtask

    always @(negedge clk) begin
        if (frame_err) fe_cycles++;
        if (rx_valid && !pv) begin
            if (exp_q.size() == 0) check("unexpected_valid", 32'(rx_valid), 0);
            else check("byte", 32'(out_data), 32'(exp_q.pop_front()));
        end
        pv = rx_valid;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #21;
        check("rst_data", 32'(out_data), 0);
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_fe", 32'(frame_err), 0);
        #1 reset = 1'b1;
        pulse_init();
        #100000;
        check("idle_valid", 32'(rx_valid), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_fe", 32'(fe_cycles), 0);
        check("idle_ovr", 32'(overrun), 0);

        // single frame, latency and hold-until-ack
        @(posedge clk);
        #5;
        exp_q.push_back(8'h6D);
        n = 0;
        fork
            send_frame(8'h6D, 1'b1);
            while (!rx_valid && n < 5000) begin
                @(posedge clk);
                #1 n++;
            end
        join
        check("latency", 32'(n >= 4127 && n <= 4129), 1);
        repeat (100) @(posedge clk);
        check("t2_hold_valid", 32'(rx_valid), 1);
        check("t2_hold_data", 32'(out_data), 32'h6D);
        ack_byte("t2");

        // back-to-back without ack -> overrun, data kept
        @(posedge clk);
        #5;
        exp_q.push_back(8'h6D);
        send_frame(8'h6D, 1'b1);
        send_frame(8'h6D, 1'b1);
        check("t3_ovr", 32'(overrun), 1);
        check("t3_data", 32'(out_data), 32'h6D);
        check("t3_pending", exp_q.size(), 0);
        ack_byte("t3a");
        pulse_init();
        check("t3_init_ovr", 32'(overrun), 0);

        // back-to-back with ack between
        @(posedge clk);
        #5;
        exp_q.push_back(8'h6D);
        exp_q.push_back(8'h6D);
        fork
            begin
                send_frame(8'h6D, 1'b1);
                send_frame(8'h6D, 1'b1);
            end
            begin
                ack_byte("t3b1");
                ack_byte("t3b2");
            end
        join
        check("t3b_ovr", 32'(overrun), 0);
        check("t3b_pending", exp_q.size(), 0);

        // false start
        @(posedge clk);
        #5 rx = 1'b0;
        #2000;
        check("fs_busy_hi", 32'(busy), 1);
        #1000 rx = 1'b1;
        #(BIT);
        check("fs_busy_lo", 32'(busy), 0);
        check("fs_valid", 32'(rx_valid), 0);

        // framing error then good frame
        fe_cycles = 0;
        @(posedge clk);
        #5;
        send_frame(8'h55, 1'b0);
        #(BIT);
        check("fe_cycles", fe_cycles, 1);
        check("fe_valid", 32'(rx_valid), 0);
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1);
        check("fe_next_data", 32'(out_data), 32'hA3);
        check("fe_pending", exp_q.size(), 0);

        // async reset mid-data with A3 still pending
        @(posedge clk);
        #5;
        fork
            send_frame(8'h3C, 1'b1);
            begin
                #(BIT * 5);
                check("mr_busy_before", 32'(busy), 1);
                reset = 1'b0;
                #1;
                check("mr_data", 32'(out_data), 0);
                check("mr_valid", 32'(rx_valid), 0);
                check("mr_busy", 32'(busy), 0);
                check("mr_ovr", 32'(overrun), 0);
                check("mr_fe", 32'(frame_err), 0);
            end
        join
        reset = 1'b1;
        @(posedge clk);
        #5;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        check("mr_next_data", 32'(out_data), 32'h3C);
        check("mr_pending", exp_q.size(), 0);

        // init mid-data with 3C still pending
        @(posedge clk);
        #5;
        fork
            send_frame(8'h3C, 1'b1);
            begin
                #(BIT * 5);
                check("mi_busy_before", 32'(busy), 1);
                @(posedge clk);
                #1 init = 1'b1;
                @(posedge clk);
                #1;
                check("mi_valid", 32'(rx_valid), 0);
                check("mi_busy", 32'(busy), 0);
                check("mi_ovr", 32'(overrun), 0);
            end
        join
        init = 1'b0;
        @(posedge clk);
        #5;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        check("mi_next_data", 32'(out_data), 32'h3C);
        ack_byte("mi");
        check("mi_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
